// File: rtl/key_debounce.sv
// key_debounce: turns one raw, bouncing push-button into a clean debounced
// level, a single-clock press pulse, a single-clock release pulse and a
// wrapping 8-bit press counter.  The press pulse is meant to trigger exactly
// one downstream action per physical press.

module key_debounce #(
    parameter int unsigned    N              = 20,
    parameter logic [N-1:0]   T_20MS         = 20'hF_4240,
    parameter bit             KEY_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       key_level,
    output logic [7:0] press_cnt
);

    // Raw pin level that means "not pressed"; the synchronizer idles here.
    localparam logic RELEASED_LEVEL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    // The wait states count T_20MS-1 down to 0, so together with the sample
    // that entered the wait state a transition needs T_20MS+1 stable samples.
    localparam logic [N-1:0] CNT_LOAD = T_20MS - N'(1);

    typedef enum logic [1:0] {
        K_IDLE         = 2'd0,
        K_PRESS_WAIT   = 2'd1,
        K_PRESSED      = 2'd2,
        K_RELEASE_WAIT = 2'd3
    } key_state_t;

    logic [1:0]  sync_q;
    logic        key_s;
    key_state_t  state_q;
    logic [N-1:0] cnt_q;
    logic        press_pulse_q;
    logic        release_pulse_q;
    logic        key_level_q;
    logic [7:0]  press_cnt_q;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RELEASED_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    // Normalise polarity so the FSM always sees 1 = pressed.
    assign key_s = KEY_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    // Debounce FSM with window counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= K_IDLE;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            key_level_q     <= 1'b0;
            press_cnt_q     <= 8'h00;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            case (state_q)
                K_IDLE: begin
                    if (key_s) begin
                        state_q <= K_PRESS_WAIT;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                K_PRESS_WAIT: begin
                    if (!key_s) begin
                        state_q <= K_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q       <= K_PRESSED;
                        press_pulse_q <= 1'b1;
                        key_level_q   <= 1'b1;
                        press_cnt_q   <= press_cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q - N'(1);
                    end
                end
                K_PRESSED: begin
                    if (!key_s) begin
                        state_q <= K_RELEASE_WAIT;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                K_RELEASE_WAIT: begin
                    if (key_s) begin
                        state_q <= K_PRESSED;
                    end else if (cnt_q == '0) begin
                        state_q         <= K_IDLE;
                        release_pulse_q <= 1'b1;
                        key_level_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - N'(1);
                    end
                end
                default: begin
                    state_q     <= K_IDLE;
                    cnt_q       <= '0;
                    key_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign key_level     = key_level_q;
    assign press_cnt     = press_cnt_q;

endmodule
